occ_link_pattern_chk: RTL and testbench
=======================================

# occ_link_pattern_chk

Synthesizable, parametrised link test-pattern generator and checker for OCC GTP/GTX channels. It produces a comma-framed incrementing-counter stream on the TX user interface, so built-in link tests no longer depend on a testbench-only stimulus. It checks the same stream on the RX user interface with a hunt/verify/lock state machine, error counters and lock-loss counting. It sits between the transceiver tile user ports (usrclk domain) and the OCC core or diagnostics registers.

## Interface
- g_BYTES, 2, word width in bytes; legal values are 2 and 4; W = 8*g_BYTES.
- g_COMMA_PERIOD_LOG2, 5, one comma word every 2^P words; legal range 2..8.
- g_LOCK_CNT, 4, consecutive error-free comma periods needed to reach LOCKED; legal range 1..15.
- g_UNLOCK_ERRS, 8, consecutive erroneous words that force LOCKED back to HUNT; legal range 1..255.
- g_ERRCNT_WIDTH, 32, width of the error counter.
- clk_i  in  1  user clock; all logic is in this single domain.
- rst_i  in  1  asynchronous, active-high reset.
- clr_i  in  1  synchronous clear of err_cnt_o and lock_loss_cnt_o.
- gen_en_i  in  1  generator advance enable.
- tx_data_o  out  W  generated word.
- tx_charisk_o  out  g_BYTES  K-character flags.
- rx_valid_i  in  1  RX word qualifier.
- rx_data_i  in  W  received word.
- rx_charisk_i  in  g_BYTES  received K flags.
- rx_disperr_i  in  g_BYTES  disparity error per byte.
- rx_notintable_i  in  g_BYTES  not-in-table error per byte.
- locked_o  out  1  checker is in LOCKED.
- err_cnt_o  out  g_ERRCNT_WIDTH  saturating count of errored words seen while LOCKED.
- lock_loss_cnt_o  out  8  saturating count of LOCKED-to-HUNT transitions.

## Operation
- Comma word: the most significant byte is 0xBC (K28.5) and every other byte is 0x95. charisk has only its MSB set (2'b10 or 4'b1000).
- Generator: free-running W-bit counter `gc`, reset to 0, wraps modulo 2^W.
  - On a cycle with gen_en_i=1: emit the comma word if gc[P-1:0]==0, otherwise emit tx_data_o=gc with charisk 0. Then gc increments.
  - On a cycle with gen_en_i=0: emit the comma word and hold gc.
- Word error: a word is errored when it differs from the expected word in data or charisk, or when any bit of rx_disperr_i or rx_notintable_i is set. Only words with rx_valid_i=1 are evaluated. Cycles with rx_valid_i=0 change no state.
- Checker expected counter `ec` is W bits wide and wraps modulo 2^W.
- HUNT (reset state): on a valid comma word, go to SEED.
- SEED: the next valid word must be non-K data with data[P-1:0]==1 and no disparity or not-in-table error.
  - If it is: set ec=data+1, clear the good-period count, go to VERIFY.
  - Otherwise: go to HUNT.
- VERIFY: each valid word is compared against the expected word (comma if ec[P-1:0]==0, else ec), then ec increments.
  - Any errored word returns the FSM to HUNT.
  - Each error-free comma increments the good-period count. When the count reaches g_LOCK_CNT, go to LOCKED.
- LOCKED: same comparison, and ec keeps free-running regardless of errors.
  - Each errored word increments err_cnt_o (saturating) and a consecutive-error count.
  - An error-free word clears the consecutive-error count.
  - When the consecutive-error count reaches g_UNLOCK_ERRS: go to HUNT and increment lock_loss_cnt_o (saturating at 255).
- Errors seen outside LOCKED are never counted.
- clr_i: zeroes both counters. If clr_i coincides with an increment, the clear wins. The FSM state is unaffected.

## Timing
- Reset values: tx_data_o = comma word, tx_charisk_o = comma mask, locked_o=0, err_cnt_o=0, lock_loss_cnt_o=0, FSM in HUNT, gc=0, ec=0.
- Generator latency: a word emitted for gc=n appears on tx_data_o in the cycle after the clk_i edge where gen_en_i=1 is sampled.
- Checker latency: an input word sampled at edge k updates locked_o, err_cnt_o and lock_loss_cnt_o, all registered, visible after edge k.
- locked_o rises in the same update as the comma that satisfies g_LOCK_CNT. It falls in the same update as the word that reaches g_UNLOCK_ERRS, and lock_loss_cnt_o increments in that same update.
- Counter wrap: ec and gc wrap from 2^W-1 to 0. Value 0 is a comma position, so a wrap causes no error.
- A comma received in an unexpected position while LOCKED is an errored word; it does not trigger resynchronisation.
- Asserting rst_i mid-stream forces all reset values immediately. Lock is reacquired via HUNT.

## Test plan
- Loopback, g_BYTES=2, P=5, g_LOCK_CNT=4, gen_en_i=1 from the first post-reset cycle.
  - Expected: tx_data_o sequence 0xBC95, 0x0001, …, 0x001F, 0xBC95, 0x0021, …
  - locked_o rises with the comma at generated word index 128, with err_cnt_o=0.
- While LOCKED, flip bit 3 of one data word → err_cnt_o=1; locked_o stays 1; lock_loss_cnt_o=0.
- While LOCKED, corrupt 8 consecutive words → locked_o drops on the 8th word; err_cnt_o increases by 8; lock_loss_cnt_o=1. locked_o returns to 1 after the next comma plus 4 clean periods.
- While LOCKED:
  - Assert rx_disperr_i=2'b01 on one otherwise-correct word → err_cnt_o increments by 1.
  - Deassert rx_valid_i for 10 cycles while holding data → no errors and no state change.
- Run 70000 words with g_BYTES=2 across the 0xFFFF→0 wrap → err_cnt_o stays 0 and locked_o stays 1.
- With g_ERRCNT_WIDTH=4, inject 20 isolated errors → err_cnt_o saturates at 15. Then assert clr_i for one cycle together with an error → err_cnt_o=0.

Source files
------------

// File: rtl/occ_link_pattern_chk.sv
// Link test-pattern generator and checker for transceiver user ports.
//
// The generator drives a comma-framed incrementing-counter stream on the TX
// user interface. The checker follows the same stream on the RX user
// interface with a hunt/seed/verify/lock state machine. While locked it
// counts errored words and the number of times lock is lost.
//
// Ports:
//   clk_i, rst_i           user clock, asynchronous active-high reset
//   clr_i                  synchronous clear of both status counters
//   gen_en_i               generator advance enable
//   tx_data_o/charisk_o    generated word and K flags (registered)
//   rx_valid_i             RX word qualifier
//   rx_data_i/charisk_i    received word and K flags
//   rx_disperr_i           per-byte disparity error
//   rx_notintable_i        per-byte not-in-table error
//   locked_o               checker is in LOCKED
//   err_cnt_o              saturating count of errored words while LOCKED
//   lock_loss_cnt_o        saturating count of LOCKED-to-HUNT transitions
//
// State table:
//   ST_HUNT   | waiting for a comma word
//   ST_SEED   | comma seen; next word seeds the expected counter
//   ST_VERIFY | comparing words, counting clean comma periods
//   ST_LOCKED | locked; counting errors and consecutive errors

module occ_link_pattern_chk #(
    parameter int g_BYTES            = 2,
    parameter int g_COMMA_PERIOD_LOG2 = 5,
    parameter int g_LOCK_CNT         = 4,
    parameter int g_UNLOCK_ERRS      = 8,
    parameter int g_ERRCNT_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      gen_en_i,
    output logic [8*g_BYTES-1:0]      tx_data_o,
    output logic [g_BYTES-1:0]        tx_charisk_o,
    input  logic                      rx_valid_i,
    input  logic [8*g_BYTES-1:0]      rx_data_i,
    input  logic [g_BYTES-1:0]        rx_charisk_i,
    input  logic [g_BYTES-1:0]        rx_disperr_i,
    input  logic [g_BYTES-1:0]        rx_notintable_i,
    output logic                      locked_o,
    output logic [g_ERRCNT_WIDTH-1:0] err_cnt_o,
    output logic [7:0]                lock_loss_cnt_o
);

    localparam int W = 8 * g_BYTES;
    localparam int P = g_COMMA_PERIOD_LOG2;

    // K28.5 in the top byte, 0x95 filler in every other byte.
    localparam logic [W-1:0]       COMMA_DATA = {8'hBC, {(g_BYTES-1){8'h95}}};
    localparam logic [g_BYTES-1:0] COMMA_K    = {1'b1, {(g_BYTES-1){1'b0}}};

    localparam logic [W-1:0]              ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [g_ERRCNT_WIDTH-1:0] ONE_ERR  = {{(g_ERRCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [P-1:0]              SEED_LSB = {{(P-1){1'b0}}, 1'b1};
    localparam logic [3:0]                LOCK_CNT = 4'(g_LOCK_CNT);
    localparam logic [7:0]                UNLOCK   = 8'(g_UNLOCK_ERRS);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SEED,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    // ------------------------------------------------------------------
    // Generator
    // ------------------------------------------------------------------
    logic [W-1:0]       gc_q, gc_d;
    logic [W-1:0]       tx_data_q, tx_data_d;
    logic [g_BYTES-1:0] tx_charisk_q, tx_charisk_d;

    always_comb begin
        gc_d         = gc_q;
        tx_data_d    = COMMA_DATA;
        tx_charisk_d = COMMA_K;
        if (gen_en_i) begin
            gc_d = gc_q + ONE_W;
            if (gc_q[P-1:0] != '0) begin
                tx_data_d    = gc_q;
                tx_charisk_d = '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    state_t                      state_q, state_d;
    logic [W-1:0]                ec_q, ec_d;
    logic [3:0]                  good_q, good_d;
    logic [7:0]                  consec_q, consec_d;
    logic [g_ERRCNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
    logic [7:0]                  loss_q, loss_d;

    logic                        exp_is_comma;
    logic [W-1:0]                exp_data;
    logic [g_BYTES-1:0]          exp_k;
    logic                        link_err;
    logic                        word_err;
    logic                        rx_is_comma;
    logic                        seed_ok;
    logic [3:0]                  good_inc;
    logic [7:0]                  consec_inc;

    always_comb begin
        exp_is_comma = (ec_q[P-1:0] == '0);
        exp_data     = exp_is_comma ? COMMA_DATA : ec_q;
        exp_k        = exp_is_comma ? COMMA_K : '0;
        link_err     = (|rx_disperr_i) | (|rx_notintable_i);
        word_err     = (rx_data_i != exp_data) || (rx_charisk_i != exp_k) || link_err;
        rx_is_comma  = (rx_data_i == COMMA_DATA) && (rx_charisk_i == COMMA_K);
        seed_ok      = (rx_charisk_i == '0) && (rx_data_i[P-1:0] == SEED_LSB) && !link_err;
        good_inc     = good_q + 4'd1;
        consec_inc   = consec_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        ec_d      = ec_q;
        good_d    = good_q;
        consec_d  = consec_q;
        err_cnt_d = err_cnt_q;
        loss_d    = loss_q;

        if (rx_valid_i) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (rx_is_comma) begin
                        state_d = ST_SEED;
                    end
                end
                ST_SEED: begin
                    if (seed_ok) begin
                        ec_d    = rx_data_i + ONE_W;
                        good_d  = '0;
                        state_d = ST_VERIFY;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    ec_d = ec_q + ONE_W;
                    if (word_err) begin
                        state_d = ST_HUNT;
                    end else if (exp_is_comma) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_CNT) begin
                            state_d  = ST_LOCKED;
                            consec_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // ec free-runs so a burst of errors does not shift alignment.
                    ec_d = ec_q + ONE_W;
                    if (word_err) begin
                        consec_d = consec_inc;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ONE_ERR;
                        end
                        if (consec_inc == UNLOCK) begin
                            state_d = ST_HUNT;
                            if (loss_q != 8'hFF) begin
                                loss_d = loss_q + 8'd1;
                            end
                        end
                    end else begin
                        consec_d = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        // Clear overrides any increment in the same cycle.
        if (clr_i) begin
            err_cnt_d = '0;
            loss_d    = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gc_q         <= '0;
            tx_data_q    <= COMMA_DATA;
            tx_charisk_q <= COMMA_K;
            state_q      <= ST_HUNT;
            ec_q         <= '0;
            good_q       <= '0;
            consec_q     <= '0;
            err_cnt_q    <= '0;
            loss_q       <= '0;
        end else begin
            gc_q         <= gc_d;
            tx_data_q    <= tx_data_d;
            tx_charisk_q <= tx_charisk_d;
            state_q      <= state_d;
            ec_q         <= ec_d;
            good_q       <= good_d;
            consec_q     <= consec_d;
            err_cnt_q    <= err_cnt_d;
            loss_q       <= loss_d;
        end
    end

    assign tx_data_o       = tx_data_q;
    assign tx_charisk_o    = tx_charisk_q;
    assign locked_o        = (state_q == ST_LOCKED);
    assign err_cnt_o       = err_cnt_q;
    assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_occ_link_pattern_chk.sv
// Scoreboard bench for occ_link_pattern_chk.
// dut_m: default parameters, looped back through a corruption layer.
// dut_s: 4-bit error counter, used for saturation and clear.

module tb_occ_link_pattern_chk;

    logic clk;
    logic rst;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance
    logic        gen_en_m, valid_m, clr_m, hold_m;
    logic [15:0] flip_m, hold_d, rx_data_m, tx_data_m;
    logic [1:0]  derr_m, nit_m, hold_k, rx_k_m, tx_k_m;
    logic        locked_m;
    logic [31:0] err_m;
    logic [7:0]  loss_m;

    always_comb begin
        rx_data_m = hold_m ? hold_d : (tx_data_m ^ flip_m);
        rx_k_m    = hold_m ? hold_k : tx_k_m;
    end

    occ_link_pattern_chk dut_m (
        .clk_i           (clk),
        .rst_i           (rst),
        .clr_i           (clr_m),
        .gen_en_i        (gen_en_m),
        .tx_data_o       (tx_data_m),
        .tx_charisk_o    (tx_k_m),
        .rx_valid_i      (valid_m),
        .rx_data_i       (rx_data_m),
        .rx_charisk_i    (rx_k_m),
        .rx_disperr_i    (derr_m),
        .rx_notintable_i (nit_m),
        .locked_o        (locked_m),
        .err_cnt_o       (err_m),
        .lock_loss_cnt_o (loss_m)
    );

    // saturation instance
    logic        gen_en_s, valid_s, clr_s;
    logic [15:0] flip_s, rx_data_s, tx_data_s;
    logic [1:0]  derr_s, nit_s, tx_k_s;
    logic        locked_s;
    logic [3:0]  err_s;
    logic [7:0]  loss_s;

    assign rx_data_s = tx_data_s ^ flip_s;

    occ_link_pattern_chk #(.g_ERRCNT_WIDTH(4)) dut_s (
        .clk_i           (clk),
        .rst_i           (rst),
        .clr_i           (clr_s),
        .gen_en_i        (gen_en_s),
        .tx_data_o       (tx_data_s),
        .tx_charisk_o    (tx_k_s),
        .rx_valid_i      (valid_s),
        .rx_data_i       (rx_data_s),
        .rx_charisk_i    (tx_k_s),
        .rx_disperr_i    (derr_s),
        .rx_notintable_i (nit_s),
        .locked_o        (locked_s),
        .err_cnt_o       (err_s),
        .lock_loss_cnt_o (loss_s)
    );

    // scoreboard
    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [1:0]  k;
    } tx_exp_t;

    typedef struct {
        int          cyc;
        int          inst;
        logic        lk;
        logic [31:0] ec;
        logic [7:0]  ll;
    } st_exp_t;

    tx_exp_t tx_q[$];
    st_exp_t st_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    logic        e_lk;
    logic [31:0] e_err;
    logic [7:0]  e_loss;
    int          gen_n;

    task automatic check(input string name, input int at, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, at, act, exp);
    endtask

    always @(negedge clk) begin
        tx_exp_t     te;
        st_exp_t     se;
        logic        a_lk;
        logic [31:0] a_ec;
        logic [7:0]  a_ll;
        while (tx_q.size() > 0 && tx_q[0].cyc <= cyc) begin
            te = tx_q.pop_front();
            if (te.cyc != cyc) check("tx_schedule", cyc, 32'(te.cyc), 32'(cyc));
            check("tx_word", cyc, {14'd0, tx_k_m, tx_data_m}, {14'd0, te.k, te.d});
        end
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            se = st_q.pop_front();
            if (se.cyc != cyc) check("st_schedule", cyc, 32'(se.cyc), 32'(cyc));
            if (se.inst == 0) begin
                a_lk = locked_m; a_ec = err_m;           a_ll = loss_m;
            end else begin
                a_lk = locked_s; a_ec = {28'd0, err_s};  a_ll = loss_s;
            end
            check(se.inst == 0 ? "m_locked" : "s_locked", cyc, {31'd0, a_lk}, {31'd0, se.lk});
            check(se.inst == 0 ? "m_err_cnt" : "s_err_cnt", cyc, a_ec, se.ec);
            check(se.inst == 0 ? "m_lock_loss" : "s_lock_loss", cyc, {24'd0, a_ll}, {24'd0, se.ll});
        end
    end

    function automatic void push_tx(input int at, input int n, input bit force_comma);
        tx_exp_t     t;
        logic [31:0] nv;
        nv    = n;
        t.cyc = at;
        if (force_comma || nv[4:0] == 5'd0) begin
            t.d = 16'hBC95;
            t.k = 2'b10;
        end else begin
            t.d = nv[15:0];
            t.k = 2'b00;
        end
        tx_q.push_back(t);
    endfunction

    function automatic void push_st(input int at, input int inst);
        st_exp_t s;
        s.cyc  = at;
        s.inst = inst;
        s.lk   = e_lk;
        s.ec   = e_err;
        s.ll   = e_loss;
        st_q.push_back(s);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present the word currently on tx to the checker for one cycle.
    task automatic drive_word(input int inst, input logic [15:0] flip,
                              input logic [1:0] de, input logic clr);
        if (inst == 0) begin
            valid_m = 1'b1; flip_m = flip; derr_m = de; clr_m = clr;
            push_tx(cyc + 1, gen_n, 1'b0);
            gen_n++;
        end else begin
            valid_s = 1'b1; flip_s = flip; clr_s = clr;
        end
        push_st(cyc + 1, inst);
        step();
        flip_m = '0; derr_m = '0; clr_m = 1'b0;
        flip_s = '0; clr_s = 1'b0;
    endtask

    task automatic clean_words(input int inst, input int n);
        for (int i = 0; i < n; i++) drive_word(inst, 16'h0000, 2'b00, 1'b0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        gen_en_m = 0; valid_m = 0; clr_m = 0; hold_m = 0;
        flip_m = '0; derr_m = '0; nit_m = '0; hold_d = '0; hold_k = '0;
        gen_en_s = 0; valid_s = 0; clr_s = 0;
        flip_s = '0; derr_s = '0; nit_s = '0;
        e_lk = 0; e_err = 0; e_loss = 0; gen_n = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        push_st(cyc, 0);
        push_st(cyc, 1);
        push_tx(cyc, 0, 1'b1);

        // start generator; word 0 appears after the next edge
        gen_en_m = 1'b1;
        push_tx(cyc + 1, 0, 1'b0);
        gen_n = 1;
        step();

        // words 0..127: hunting/verifying; lock at comma word 128
        clean_words(0, 128);
        e_lk = 1'b1;
        clean_words(0, 13);                       // 128..140
        e_err = 1;
        drive_word(0, 16'h0008, 2'b00, 1'b0);     // 141: single bit flip
        clean_words(0, 8);                        // 142..149
        for (int k = 0; k < 8; k++) begin         // 150..157: burst
            e_err = e_err + 1;
            if (k == 7) begin
                e_lk   = 1'b0;
                e_loss = 8'd1;
            end
            drive_word(0, 16'h0001, 2'b00, 1'b0);
        end
        clean_words(0, 130);                      // 158..287: relock via comma 160
        e_lk = 1'b1;
        clean_words(0, 12);                       // 288..299
        e_err = 10;
        drive_word(0, 16'h0000, 2'b01, 1'b0);     // 300: disparity error only
        clean_words(0, 9);                        // 301..309

        // valid gap: word 310 held on rx, generator paused (emits commas)
        hold_d = tx_data_m;
        hold_k = tx_k_m;
        hold_m = 1'b1;
        gen_en_m = 1'b0;
        valid_m  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_tx(cyc + 1, 0, 1'b1);
            push_st(cyc + 1, 0);
            step();
        end
        gen_en_m = 1'b1;
        drive_word(0, 16'h0000, 2'b00, 1'b0);     // 310 consumed, gen resumes at 311
        hold_m = 1'b0;

        // long run through the 0xFFFF -> 0 wrap
        clean_words(0, 69700);                    // 311..70010

        gen_en_m = 1'b0;
        valid_m  = 1'b0;
        step();

        // mid-stream reset
        rst = 1'b1;
        e_lk = 0; e_err = 0; e_loss = 0;
        push_st(cyc, 0);
        push_st(cyc, 1);
        push_tx(cyc, 0, 1'b1);
        step();
        step();
        rst = 1'b0;

        // saturation instance
        gen_en_s = 1'b1;
        step();
        clean_words(1, 128);                      // 0..127
        e_lk = 1'b1;
        clean_words(1, 2);                        // 128..129
        for (int k = 1; k <= 20; k++) begin       // 130..169: isolated errors
            e_err = (k > 15) ? 32'd15 : 32'(k);
            drive_word(1, 16'h0001, 2'b00, 1'b0);
            drive_word(1, 16'h0000, 2'b00, 1'b0);
        end
        e_err = 0;
        drive_word(1, 16'h0001, 2'b00, 1'b1);     // 170: clear beats increment
        clean_words(1, 2);

        valid_s  = 1'b0;
        gen_en_s = 1'b0;
        step();
        step();

        check("queues_drained", cyc, 32'(tx_q.size() + st_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
